// File: rtl/div_pkg.sv
// Shared types and default widths for the divider result buffer.
// The result record is the unit stored in the result FIFO and handed downstream.
package div_pkg;

    localparam int DIV_DIVIDEND_W = 16;
    localparam int DIV_DIVISOR_W  = 8;
    localparam int DIV_LATENCY    = 16;
    localparam int DIV_DEPTH      = 4;

    // One buffered divider result. Field order is quotient, remainder, dbz (MSB first).
    typedef struct packed {
        logic [DIV_DIVIDEND_W-1:0] quotient;
        logic [DIV_DIVISOR_W-1:0]  remainder;
        logic                      dbz;
    } div_result_t;

endpackage

// File: rtl/div_result_fifo.sv
// Result FIFO for div_result_buffer: DEPTH entries (power of two, at least 2).
// The entry type is a parameter. Pointers wrap naturally at DEPTH.
// Occupancy runs 0..DEPTH and is exported so the owner can run credit flow control.
// Storage is not reset; only pointers and occupancy are.
module div_result_fifo
    import div_pkg::*;
#(
    parameter int  DEPTH   = DIV_DEPTH,
    parameter type entry_t = div_result_t
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = DEPTH[PW:0];

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Entry storage: write at the tail on push.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // Upstream credit accounting must never let a result arrive with no free slot.
    assert property (@(posedge clock) disable iff (!reset_n)
        !(push && !pop && (count == FULL)));

endmodule

// File: rtl/div_result_buffer.sv
// div_result_buffer: front end and result buffer for a non-stallable pipelined divider.
// Operands pass straight through to the divider.
// A LATENCY-deep tag pipeline follows each accepted operation, and results land in a
// small FIFO when their tag reaches the last stage.
// Since the divider cannot stall, upstream is throttled by credit:
// an operation is accepted only if a FIFO slot is guaranteed for it on arrival.
// Optional feature macro: DIV_DBZ_SATURATE_EN. When it is defined, divide-by-zero
// results are stored as quotient all-ones, remainder zero.
module div_result_buffer
    import div_pkg::*;
#(
    parameter int DIVIDEND = DIV_DIVIDEND_W,
    parameter int DIVISOR  = DIV_DIVISOR_W,
    parameter int LATENCY  = DIV_LATENCY,
    parameter int DEPTH    = DIV_DEPTH
) (
    input  logic                clock,
    input  logic                reset_n,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIVIDEND-1:0] in_dividend,
    input  logic [DIVISOR-1:0]  in_divisor,

    output logic [DIVIDEND-1:0] div_dividend,
    output logic [DIVISOR-1:0]  div_divisor,
    input  logic [DIVIDEND-1:0] div_quotient,
    input  logic [DIVISOR-1:0]  div_remainder,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [DIVIDEND-1:0] out_quotient,
    output logic [DIVISOR-1:0]  out_remainder,
    output logic                out_dbz
);

    // Same layout as div_pkg::div_result_t, but sized from this instance's parameters
    // so that non-default widths still work.
    typedef struct packed {
        logic [DIVIDEND-1:0] quotient;
        logic [DIVISOR-1:0]  remainder;
        logic                dbz;
    } entry_t;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(LATENCY + 1);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    logic [LATENCY-1:0] tag_valid;
    logic [LATENCY-1:0] tag_dbz;
    logic [IW-1:0]      inflight;
    logic [CW-1:0]      fifo_count;
    logic [SW-1:0]      credit_used;
    logic               ready_en;
    logic               accept;
    logic               push;
    logic               pop;
    logic               last_valid;
    logic               last_dbz;
    entry_t             push_data;
    entry_t             head;

    assign div_dividend = in_dividend;
    assign div_divisor  = in_divisor;

    assign accept     = in_valid && in_ready;
    assign last_valid = tag_valid[LATENCY-1];
    assign last_dbz   = tag_dbz[LATENCY-1];
    assign push       = last_valid;

    // Results already buffered plus results still inside the divider must fit in the FIFO.
    assign credit_used = SW'(fifo_count) + SW'(inflight);
    assign in_ready    = ready_en && (credit_used < SW'(DEPTH));

    // Holds off acceptance until the first clock after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Tag pipeline that tracks each accepted operation and its divide-by-zero flag alongside the divider.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= '0;
            tag_dbz   <= '0;
        end else begin
            tag_valid[0] <= accept;
            tag_dbz[0]   <= (in_divisor == '0);
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_dbz[i]   <= tag_dbz[i-1];
            end
        end
    end

    // Running count of valid tag stages: it enters at stage 0 and leaves from the last stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else begin
            case ({accept, last_valid})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Build the entry to store from the divider outputs, applying optional divide-by-zero saturation.
    always_comb begin
        push_data.quotient  = div_quotient;
        push_data.remainder = div_remainder;
        push_data.dbz       = last_dbz;
`ifdef DIV_DBZ_SATURATE_EN
        if (last_dbz) begin
            push_data.quotient  = '1;
            push_data.remainder = '0;
        end
`endif
    end

    div_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // Stale storage is never exposed: data outputs read zero whenever the FIFO is empty, including during reset.
    assign out_valid     = (fifo_count != '0);
    assign pop           = out_valid && out_ready;
    assign out_quotient  = out_valid ? head.quotient  : '0;
    assign out_remainder = out_valid ? head.remainder : '0;
    assign out_dbz       = out_valid ? head.dbz       : 1'b0;

endmodule

// File: tb/tb_div_result_buffer.sv
// Directed testbench for div_result_buffer with a behavioural pipelined divider model.
// On divide-by-zero, the model divider returns 16'hDEAD / 8'h5A as its raw result.
module tb_div_result_buffer;

    localparam int DIVIDEND = 16;
    localparam int DIVISOR  = 8;
    localparam int LATENCY  = 16;
    localparam int DEPTH    = 4;
    localparam logic [15:0] RAW_DBZ_Q = 16'hDEAD;
    localparam logic [7:0]  RAW_DBZ_R = 8'h5A;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DIVIDEND-1:0] in_dividend = '0;
    logic [DIVISOR-1:0]  in_divisor = 8'd1;
    logic [DIVIDEND-1:0] div_dividend;
    logic [DIVISOR-1:0]  div_divisor;
    logic [DIVIDEND-1:0] div_quotient;
    logic [DIVISOR-1:0]  div_remainder;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [DIVIDEND-1:0] out_quotient;
    logic [DIVISOR-1:0]  out_remainder;
    logic                out_dbz;
    logic [24:0]         out_tuple;

    int n_compared   = 0;
    int n_mismatched = 0;

    div_result_buffer #(
        .DIVIDEND (DIVIDEND),
        .DIVISOR  (DIVISOR),
        .LATENCY  (LATENCY),
        .DEPTH    (DEPTH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_dbz       (out_dbz)
    );

    always #5 clock = ~clock;

    assign out_tuple = {out_quotient, out_remainder, out_dbz};

    // Pipelined divider model: operands sampled every edge, result valid LATENCY cycles later.
    logic [15:0] pipe_a [LATENCY];
    logic [7:0]  pipe_b [LATENCY];
    logic [15:0] rem_full;
    always @(posedge clock) begin
        pipe_a[0] <= div_dividend;
        pipe_b[0] <= div_divisor;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign div_quotient  = (pipe_b[LATENCY-1] == 8'd0) ? RAW_DBZ_Q
                         : pipe_a[LATENCY-1] / {8'h00, pipe_b[LATENCY-1]};
    assign rem_full      = (pipe_b[LATENCY-1] == 8'd0) ? {8'h00, RAW_DBZ_R}
                         : pipe_a[LATENCY-1] % {8'h00, pipe_b[LATENCY-1]};
    assign div_remainder = rem_full[7:0];

    function automatic logic [24:0] expect_result(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] q;
        logic [15:0] rf;
        if (b == 8'd0) begin
`ifdef DIV_DBZ_SATURATE_EN
            return {16'hFFFF, 8'h00, 1'b1};
`else
            return {RAW_DBZ_Q, RAW_DBZ_R, 1'b1};
`endif
        end
        q  = a / {8'h00, b};
        rf = a % {8'h00, b};
        return {q, rf[7:0], 1'b0};
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        n_compared++;
        if (in_ready !== 1'b0) begin
            n_mismatched++; $display("FAIL rst_ready: got %b want 0", in_ready);
        end
        n_compared++;
        if ({out_valid, out_tuple} !== 26'd0) begin
            n_mismatched++; $display("FAIL rst_outputs: got %h want 0", {out_valid, out_tuple});
        end
        reset_n = 1'b1;
        #1;
        n_compared++;
        if (in_ready !== 1'b0) begin
            n_mismatched++; $display("FAIL rst_ready_before_clock: got %b want 0", in_ready);
        end
        step();
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_mismatched++; $display("FAIL rst_ready_after_clock: got %b want 1", in_ready);
        end
    endtask

    // 100/7: the accept cycle is cycle 0; out_valid is first high in cycle LATENCY+1.
    task automatic test_single();
        logic early;
        early       = 1'b0;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_dividend = 16'd100;
        in_divisor  = 8'd7;
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_mismatched++; $display("FAIL single_ready: got %b want 1", in_ready);
        end
        n_compared++;
        if ({div_dividend, div_divisor} !== {16'd100, 8'd7}) begin
            n_mismatched++; $display("FAIL single_passthru: got %h want %h", {div_dividend, div_divisor}, {16'd100, 8'd7});
        end
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= LATENCY; c++) begin
            if (out_valid !== 1'b0) early = 1'b1;
            step();
        end
        n_compared++;
        if (early !== 1'b0) begin
            n_mismatched++; $display("FAIL single_early_valid: got %b want 0", early);
        end
        n_compared++;
        if (out_valid !== 1'b1) begin
            n_mismatched++; $display("FAIL single_valid: got %b want 1", out_valid);
        end
        n_compared++;
        if (out_tuple !== {16'd14, 8'd2, 1'b0}) begin
            n_mismatched++; $display("FAIL single_result: got %h want %h", out_tuple, {16'd14, 8'd2, 1'b0});
        end
        step();
        n_compared++;
        if (out_valid !== 1'b0) begin
            n_mismatched++; $display("FAIL single_drained: got %b want 0", out_valid);
        end
    endtask

    task automatic test_stream();
        logic [15:0] sa [8];
        logic [7:0]  sb [8];
        logic [24:0] se [4];
        int idx;
        int rd;
        sa = '{16'd1000, 16'd2000, 16'd65535, 16'd12345, 16'd500, 16'd42, 16'd7, 16'd300};
        sb = '{8'd3, 8'd7, 8'd255, 8'd100, 8'd9, 8'd42, 8'd8, 8'd1};
        se = '{{16'd333, 8'd1, 1'b0}, {16'd285, 8'd5, 1'b0},
               {16'd257, 8'd0, 1'b0}, {16'd123, 8'd45, 1'b0}};
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 2*LATENCY; c++) begin
            if (idx < 8) begin
                in_valid    = 1'b1;
                in_dividend = sa[idx];
                in_divisor  = sb[idx];
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid = 1'b0;
        n_compared++;
        if (idx !== DEPTH) begin
            n_mismatched++; $display("FAIL stream_accepts: got %0d want %0d", idx, DEPTH);
        end
        n_compared++;
        if (in_ready !== 1'b0) begin
            n_mismatched++; $display("FAIL stream_blocked: got %b want 0", in_ready);
        end
        out_ready = 1'b1;
        rd = 0;
        for (int c = 0; c < 20 && rd < DEPTH; c++) begin
            if (out_valid === 1'b1) begin
                n_compared++;
                if (out_tuple !== se[rd]) begin
                    n_mismatched++; $display("FAIL stream_order[%0d]: got %h want %h", rd, out_tuple, se[rd]);
                end
                rd++;
            end
            step();
        end
        n_compared++;
        if (rd !== DEPTH) begin
            n_mismatched++; $display("FAIL stream_drained: got %0d want %0d", rd, DEPTH);
        end
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_mismatched++; $display("FAIL stream_ready_back: got %b want 1", in_ready);
        end
    endtask

    task automatic test_dbz();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_dividend = 16'd50;
        in_divisor  = 8'd0;
        step();
        in_valid   = 1'b0;
        in_divisor = 8'd1;
        for (int c = 0; c < LATENCY + 4 && out_valid !== 1'b1; c++) step();
        n_compared++;
        if (out_valid !== 1'b1) begin
            n_mismatched++; $display("FAIL dbz_valid_timeout: got %b want 1", out_valid);
        end
        n_compared++;
        if (out_dbz !== 1'b1) begin
            n_mismatched++; $display("FAIL dbz_flag: got %b want 1", out_dbz);
        end
`ifdef DIV_DBZ_SATURATE_EN
        n_compared++;
        if ({out_quotient, out_remainder} !== {16'hFFFF, 8'h00}) begin
            n_mismatched++; $display("FAIL dbz_saturated: got %h want %h", {out_quotient, out_remainder}, {16'hFFFF, 8'h00});
        end
`else
        n_compared++;
        if ({out_quotient, out_remainder} !== {RAW_DBZ_Q, RAW_DBZ_R}) begin
            n_mismatched++; $display("FAIL dbz_raw: got %h want %h", {out_quotient, out_remainder}, {RAW_DBZ_Q, RAW_DBZ_R});
        end
`endif
        step();
        n_compared++;
        if (out_valid !== 1'b0) begin
            n_mismatched++; $display("FAIL dbz_drained: got %b want 0", out_valid);
        end
    endtask

    // Three results buffered (DEPTH-1), then the fourth arrives on the same edge as a pop.
    task automatic test_pop_push();
        logic [15:0] pa [4];
        logic [7:0]  pb [4];
        logic [24:0] pe [4];
        pa = '{16'd90, 16'd91, 16'd200, 16'd255};
        pb = '{8'd9, 8'd10, 8'd13, 8'd16};
        pe = '{{16'd10, 8'd0, 1'b0}, {16'd9, 8'd1, 1'b0},
               {16'd15, 8'd5, 1'b0}, {16'd15, 8'd15, 1'b0}};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid    = 1'b1;
            in_dividend = pa[i];
            in_divisor  = pb[i];
            step();
        end
        in_valid = 1'b0;
        repeat (LATENCY - 1) step();
        n_compared++;
        if (dut.fifo_count !== 3'd3) begin
            n_mismatched++; $display("FAIL pp_count_before: got %0d want 3", dut.fifo_count);
        end
        n_compared++;
        if (out_tuple !== pe[0]) begin
            n_mismatched++; $display("FAIL pp_head0: got %h want %h", out_tuple, pe[0]);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_compared++;
        if (dut.fifo_count !== 3'd3) begin
            n_mismatched++; $display("FAIL pp_count_after: got %0d want 3", dut.fifo_count);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            n_compared++;
            if ({out_valid, out_tuple} !== {1'b1, pe[i]}) begin
                n_mismatched++; $display("FAIL pp_drain[%0d]: got %h want %h", i, {out_valid, out_tuple}, {1'b1, pe[i]});
            end
            step();
        end
        n_compared++;
        if (out_valid !== 1'b0) begin
            n_mismatched++; $display("FAIL pp_empty: got %b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [24:0] sb_q [$];
        logic [24:0] exp;
        logic [15:0] a;
        logic [7:0]  b;
        int sent;
        int got;
        sent = 0;
        got  = 0;
        a    = '0;
        b    = 8'd1;
        for (int c = 0; c < 3000 && (sent < 100 || sb_q.size() > 0); c++) begin
            if (sent < 100 && $urandom_range(0, 3) != 0) begin
                a           = 16'($urandom);
                b           = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
                in_valid    = 1'b1;
                in_dividend = a;
                in_divisor  = b;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (sent >= 100) || ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                n_compared++;
                if (sb_q.size() == 0) begin
                    n_mismatched++; $display("FAIL rnd_spurious: got %h want none", out_tuple);
                end else begin
                    exp = sb_q.pop_front();
                    if (out_tuple !== exp) begin
                        n_mismatched++; $display("FAIL rnd_result[%0d]: got %h want %h", got, out_tuple, exp);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(expect_result(a, b));
                sent++;
            end
            step();
        end
        in_valid = 1'b0;
        n_compared++;
        if (sent !== 100) begin
            n_mismatched++; $display("FAIL rnd_sent: got %0d want 100", sent);
        end
        n_compared++;
        if (got !== 100 || sb_q.size() !== 0) begin
            n_mismatched++; $display("FAIL rnd_received: got %0d (left %0d) want 100 (left 0)", got, sb_q.size());
        end
    endtask

    task automatic test_reset_inflight();
        logic seen;
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_dividend = 16'd77;
        in_divisor  = 8'd5;
        step();
        in_valid = 1'b0;
        repeat (LATENCY) step();
        n_compared++;
        if ({out_valid, out_tuple} !== {1'b1, 16'd15, 8'd2, 1'b0}) begin
            n_mismatched++; $display("FAIL ri_pre: got %h want %h", {out_valid, out_tuple}, {1'b1, 16'd15, 8'd2, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            in_valid    = 1'b1;
            in_dividend = 16'd300 + 16'(i);
            in_divisor  = 8'd3;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        n_compared++;
        if ({out_valid, out_tuple} !== 26'd0) begin
            n_mismatched++; $display("FAIL ri_clear: got %h want 0", {out_valid, out_tuple});
        end
        n_compared++;
        if (in_ready !== 1'b0) begin
            n_mismatched++; $display("FAIL ri_ready_low: got %b want 0", in_ready);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        seen      = 1'b0;
        for (int c = 0; c < 2*LATENCY; c++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            step();
        end
        n_compared++;
        if (seen !== 1'b0) begin
            n_mismatched++; $display("FAIL ri_stale_result: got %b want 0", seen);
        end
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_mismatched++; $display("FAIL ri_ready_back: got %b want 1", in_ready);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_dbz();
        test_pop_push();
        test_random();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
